speech_sequencer: RTL

Upstream stage of the audio playback path. It accepts a queue of spoken-word tokens (digits, operators, result words) from the calculator front end and looks each one up in a constant address table. It then drives the `start`, `start_address` and `end_address` inputs of the audio controller for that token, waiting for each utterance to complete before issuing the next. Utterances are separated by a programmable silence gap.

---
 rtl/speech_pkg.sv | 28 ++
 rtl/token_fifo.sv | 58 +++++
 rtl/speech_sequencer.sv | 130 +++++++++++++
 3 files changed

// File: rtl/speech_pkg.sv
// Shared state/token types and the flash-image address table for the speech sequencer.
package speech_pkg;

    localparam int unsigned ADDR_W = 24;

    typedef enum logic [2:0] {IDLE, LOAD, REQ, PLAY, GAP} seq_state_e;

    typedef enum logic [3:0] {
        TOK_0, TOK_1, TOK_2, TOK_3, TOK_4, TOK_5, TOK_6, TOK_7, TOK_8, TOK_9,
        TOK_PLUS, TOK_MINUS, TOK_TIMES, TOK_DIV, TOK_EQUALS, TOK_POINT
    } token_e;

    // One 64 KiB slot per word; END is the byte address of the last sample.
    localparam logic [ADDR_W-1:0] TOKEN_START [16] = '{
        24'h000000, 24'h010000, 24'h020000, 24'h030000,
        24'h040000, 24'h050000, 24'h060000, 24'h070000,
        24'h080000, 24'h090000, 24'h0A0000, 24'h0B0000,
        24'h0C0000, 24'h0D0000, 24'h0E0000, 24'h0F0000
    };

    localparam logic [ADDR_W-1:0] TOKEN_END [16] = '{
        24'h00A3FF, 24'h0187FF, 24'h0289FF, 24'h038BFF,
        24'h049FFF, 24'h05A7FF, 24'h068FFF, 24'h07B3FF,
        24'h0887FF, 24'h099BFF, 24'h0A93FF, 24'h0BA3FF,
        24'h0C8BFF, 24'h0DBFFF, 24'h0EC7FF, 24'h0F77FF
    };

endpackage

// File: rtl/token_fifo.sv
// Synchronous token FIFO; pointers carry one extra wrap bit so full and empty are distinct.
module token_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    push,
    input  logic                    pop,
    input  logic                    flush,
    input  logic [WIDTH-1:0]        wdata,
    output logic [WIDTH-1:0]        rdata,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    full,
    output logic                    empty
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    assign count   = wr_ptr_q - rd_ptr_q;
    assign full    = (count == FULL_CNT);
    assign empty   = (wr_ptr_q == rd_ptr_q);
    // Flush dominates: a same-cycle push or pop is dropped.
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign rdata   = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            rd_ptr_d = wr_ptr_q;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/speech_sequencer.sv
// Plays queued word tokens through the audio controller, one utterance at a time with a silence gap.
module speech_sequencer
    import speech_pkg::*;
#(
    parameter int unsigned DEPTH       = 8,
    parameter logic [23:0] GAP_CYCLES  = 24'd2_500_000,
    parameter logic [15:0] ACK_TIMEOUT = 16'd1000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [3:0]             token,
    input  logic                   push_valid,
    output logic                   push_ready,
    input  logic                   flush,
    output logic                   start,
    output logic [23:0]            start_address,
    output logic [23:0]            end_address,
    input  logic                   finish,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] count,
    output logic                   error
);
    seq_state_e  state_q, state_d;
    logic [23:0] start_addr_q, start_addr_d, end_addr_q, end_addr_d;
    logic [23:0] gap_cnt_q, gap_cnt_d;
    logic [15:0] ack_cnt_q, ack_cnt_d;
    logic        error_q, error_d;
    logic        fifo_pop, fifo_full, fifo_empty;
    logic        gap_done, ack_expired;
    logic [3:0]  head_token;

    token_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (4)
    ) u_token_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_valid),
        .pop   (fifo_pop),
        .flush (flush),
        .wdata (token),
        .rdata (head_token),
        .count (count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Terminal tests in 25/17 bits so a zero parameter still yields one cycle.
    assign gap_done    = ({1'b0, gap_cnt_q} + 25'd1) >= {1'b0, GAP_CYCLES};
    assign ack_expired = ({1'b0, ack_cnt_q} + 17'd1) >= {1'b0, ACK_TIMEOUT};

    always_comb begin
        state_d      = state_q;
        start_addr_d = start_addr_q;
        end_addr_d   = end_addr_q;
        gap_cnt_d    = '0;
        ack_cnt_d    = '0;
        error_d      = error_q;
        fifo_pop     = 1'b0;
        start        = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!fifo_empty && finish) state_d = LOAD;
            end
            LOAD: begin
                fifo_pop = 1'b1;
                // Empty here only if a flush landed on the cycle we entered LOAD.
                if (fifo_empty) begin
                    state_d = IDLE;
                end else if (end_addr_q < start_addr_q) begin
                    state_d = GAP;
                end else begin
                    state_d = REQ;
                end
            end
            REQ: begin
                start = 1'b1;
                if (!finish) begin
                    state_d = PLAY;
                end else if (ack_expired) begin
                    error_d = 1'b1;
                    state_d = GAP;
                end else begin
                    ack_cnt_d = ack_cnt_q + 16'd1;
                end
            end
            PLAY: begin
                if (finish) state_d = GAP;
            end
            GAP: begin
                if (gap_done) begin
                    state_d = fifo_empty ? IDLE : LOAD;
                end else begin
                    gap_cnt_d = gap_cnt_q + 24'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        // Capture addresses on entry to LOAD so they lead start by one cycle.
        if (state_d == LOAD) begin
            start_addr_d = TOKEN_START[head_token];
            end_addr_d   = TOKEN_END[head_token];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            start_addr_q <= '0;
            end_addr_q   <= '0;
            gap_cnt_q    <= '0;
            ack_cnt_q    <= '0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            start_addr_q <= start_addr_d;
            end_addr_q   <= end_addr_d;
            gap_cnt_q    <= gap_cnt_d;
            ack_cnt_q    <= ack_cnt_d;
            error_q      <= error_d;
        end
    end

    assign push_ready    = !fifo_full;
    assign busy          = (state_q != IDLE) || !fifo_empty;
    assign start_address = start_addr_q;
    assign end_address   = end_addr_q;
    assign error         = error_q;

endmodule
